// File: rtl/wrr_burst_arbiter_if.sv
// Request/grant bundle between PORTNUM requesters, the weighted arbiter and
// the downstream resource that reports accepted beats.
interface wrr_burst_arbiter_if #(
    parameter int PORTNUM  = 16,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(PORTNUM)
);
    logic [PORTNUM-1:0]          req;
    logic [PORTNUM*WEIGHT_W-1:0] weight;
    logic                        schedule_en;
    logic                        beat;
    logic [PORTNUM-1:0]          gnt;
    logic [IDX_W-1:0]            gnt_idx;
    logic                        gnt_vld;

    modport slave (
        input  req,
        input  weight,
        input  schedule_en,
        input  beat,
        output gnt,
        output gnt_idx,
        output gnt_vld
    );

    modport master (
        output req,
        output weight,
        output schedule_en,
        output beat,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld
    );
endinterface

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to the
// winner's weight in accepted beats, with back-to-back re-arbitration on release.
//
//   state | meaning
//   IDLE  | no holder; gnt=0, arbitrate whenever schedule_en is set
//   HOLD  | gnt_idx owns the resource; cnt counts remaining credits down
module wrr_burst_arbiter #(
    parameter int PORTNUM  = 16,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(PORTNUM)
) (
    input logic               clk,
    input logic               rst_n,
    wrr_burst_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(PORTNUM - 1);
    localparam logic [WEIGHT_W-1:0] ONE_CNT  = WEIGHT_W'(1);

    state_t              state_q, state_d;
    logic [PORTNUM-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] cnt_q, cnt_d;

    logic                hi_vld, lo_vld;
    logic [IDX_W-1:0]    hi_idx, lo_idx;
    logic                win_vld;
    logic [IDX_W-1:0]    win_idx;
    logic [WEIGHT_W-1:0] win_weight;
    logic                holder_req;
    logic                rel;
    logic                arb;

    // Two downward scans leave the lowest set bit at or above ptr (hi) and the
    // lowest set bit overall (lo, used on wrap-around).
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = PORTNUM - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_vld = 1'b1;
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
    end

    assign win_vld = lo_vld;
    assign win_idx = hi_vld ? hi_idx : lo_idx;

    always_comb begin
        win_weight = '0;
        holder_req = 1'b0;
        for (int i = 0; i < PORTNUM; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_weight = bus.weight[i*WEIGHT_W +: WEIGHT_W];
            end
            if (gnt_idx_q == IDX_W'(i)) begin
                holder_req = bus.req[i];
            end
        end
    end

    assign rel = (state_q == HOLD) && ((bus.beat && (cnt_q == ONE_CNT)) || !holder_req);
    assign arb = bus.schedule_en && ((state_q == IDLE) || rel);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        if ((state_q == HOLD) && bus.beat && (cnt_q > ONE_CNT)) begin
            cnt_d = cnt_q - ONE_CNT;
        end

        if (arb && win_vld) begin
            state_d          = HOLD;
            gnt_d            = '0;
            gnt_d[win_idx]   = 1'b1;
            gnt_idx_d        = win_idx;
            // A zero weight still buys one beat so the port cannot be starved.
            cnt_d            = (win_weight == '0) ? ONE_CNT : win_weight;
            ptr_d            = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
        end else if (rel) begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = (state_q == HOLD);

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Scoreboard bench for wrr_burst_arbiter (4 ports): a rotation/credit model
// predicts each registered grant, a monitor compares after every edge.
module tb_wrr_burst_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [1:0]   idx;
        logic         vld;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    wrr_burst_arbiter_if #(.PORTNUM(N), .WEIGHT_W(WW)) bus ();

    wrr_burst_arbiter #(.PORTNUM(N), .WEIGHT_W(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    // Reference: who holds, how many beats it has used of its limit, and the
    // port that has first claim at the next decision.
    int m_holder = -1;
    int m_used   = 0;
    int m_limit  = 0;
    int m_ptr    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*WW-1:0] wts,
                              input logic s, input logic b);
        bit rel = 0;
        int w = -1;
        int lim;
        exp_t e;
        if (m_holder >= 0) begin
            if (!r[m_holder]) rel = 1;
            else if (b) begin
                m_used++;
                if (m_used >= m_limit) rel = 1;
            end
        end
        if (s && (m_holder < 0 || rel)) begin
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (w < 0 && r[c]) w = c;
            end
        end
        if (w >= 0) begin
            lim      = int'(wts[w*WW +: WW]);
            m_holder = w;
            m_used   = 0;
            m_limit  = (lim == 0) ? 1 : lim;
            m_ptr    = (w + 1) % N;
        end else if (rel) begin
            m_holder = -1;
        end
        e.gnt = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
        e.idx = (m_holder >= 0) ? 2'(m_holder) : 2'd0;
        e.vld = (m_holder >= 0);
        exp_q.push_back(e);
    endtask

    // One clock: drive at the falling edge, predict, return just after the rising edge.
    task automatic cycle(input logic [N-1:0] r, input logic [N*WW-1:0] wts,
                         input logic s, input logic b);
        @(negedge clk);
        bus.req         = r;
        bus.weight      = wts;
        bus.schedule_en = s;
        bus.beat        = b;
        model_step(r, wts, s, b);
        @(posedge clk);
        #3;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_gnt"}, 32'(bus.gnt), 0);
        chk({name, "_idx"}, 32'(bus.gnt_idx), 0);
        chk({name, "_vld"}, 32'(bus.gnt_vld), 0);
    endtask

    // Asserted off-edge so the zero outputs can only come from the async path.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        exp_q.delete();
        m_holder = -1;
        m_used   = 0;
        m_limit  = 0;
        m_ptr    = 0;
        bus.req         = 4'hF;
        bus.schedule_en = 1'b1;
        bus.beat        = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_idle("in_rst");
        end
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_gnt", 32'(bus.gnt), 32'(e.gnt));
                chk("sb_idx", 32'(bus.gnt_idx), 32'(e.idx));
                chk("sb_vld", 32'(bus.gnt_vld), 32'(e.vld));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          seq [11];
        logic [N-1:0]    r;
        logic [N*WW-1:0] w;
        logic            s, b;

        seq = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
        bus.req = '0;
        bus.weight = '0;
        bus.schedule_en = 1'b0;
        bus.beat = 1'b0;

        // Weighted rotation p0 x1, p1 x2, p2 x3, p3 x4, then p0 again.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(4'hF, 16'h4321, 1'b1, 1'b1);
            chk("wrr_seq_idx", 32'(bus.gnt_idx), seq[i]);
            chk("wrr_seq_vld", 32'(bus.gnt_vld), 1);
        end

        // Zero weight behaves as one beat; sole requester keeps being re-granted.
        do_reset();
        repeat (4) begin
            cycle(4'b0100, 16'h4021, 1'b1, 1'b1);
            chk("w0_regrant", 32'(bus.gnt), 32'h4);
        end
        cycle(4'b0101, 16'h4021, 1'b1, 1'b1);
        chk("w0_p0_wins", 32'(bus.gnt), 32'h1);

        // Holder drops its request mid-burst.
        do_reset();
        cycle(4'b1000, 16'h4444, 1'b1, 1'b0);
        repeat (2) cycle(4'b1001, 16'h4444, 1'b1, 1'b1);
        chk("trunc_hold", 32'(bus.gnt), 32'h8);
        cycle(4'b0001, 16'h4444, 1'b1, 1'b1);
        chk("trunc_rel", 32'(bus.gnt), 32'h1);

        // schedule_en low lets the burst finish, then idles; ptr sits at 2.
        do_reset();
        cycle(4'b0010, 16'h4434, 1'b1, 1'b0);
        repeat (2) begin
            cycle(4'b0110, 16'h4434, 1'b0, 1'b1);
            chk("sched_off_hold", 32'(bus.gnt), 32'h2);
        end
        cycle(4'b0110, 16'h4434, 1'b0, 1'b1);
        chk("sched_off_rel", 32'(bus.gnt_vld), 0);
        cycle(4'b0110, 16'h4434, 1'b0, 1'b0);
        chk("sched_off_idle", 32'(bus.gnt), 0);
        cycle(4'b0110, 16'h4434, 1'b1, 1'b0);
        chk("sched_on_p2", 32'(bus.gnt), 32'h4);

        // Reset in the middle of a p2 burst, then restart from ptr=0.
        do_reset();
        cycle(4'b0100, 16'h4444, 1'b1, 1'b1);
        cycle(4'b0100, 16'h4444, 1'b1, 1'b1);
        chk("pre_rst_p2", 32'(bus.gnt), 32'h4);
        do_reset();
        cycle(4'hF, 16'h4444, 1'b1, 1'b0);
        chk("post_rst_p0", 32'(bus.gnt), 32'h1);

        // Randomized traffic with occasional weight changes and resets.
        r = 4'($urandom_range(0, 15));
        w = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) w = 16'($urandom);
            s = ($urandom_range(0, 7) != 0);
            b = ($urandom_range(0, 3) != 0);
            cycle(r, w, s, b);
        end

        repeat (2) @(posedge clk);
        #3;
        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
